// File: rtl/spi_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the SPI TX write arbiter.
package spi_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

   localparam int unsigned STAT_WIDTH = 16;
   localparam int unsigned MAX_REQ    = 8;

   // Returns {hit, index}: first set bit of valid[n-1:0] at or after ptr, wrapping modulo n.
   function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input logic [2:0]         ptr,
                                          input int unsigned        n);
      logic [3:0]  res;
      int unsigned idx;
      res = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = ({29'd0, ptr} + k) % n;
         if (k < n && !res[3] && valid[idx[2:0]]) begin
            res = {1'b1, idx[2:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin selector: first valid requester at or after ptr.
module spi_rr_picker import spi_arb_pkg::*; #(
   parameter  int unsigned NUM_REQ = 3,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    idx,
   output logic               hit
);

   logic [MAX_REQ-1:0] req_ext;
   logic [2:0]         ptr_ext;
   logic [3:0]         pick;
   logic               unused_pick;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req;
      ptr_ext                = '0;
      ptr_ext[ID_W-1:0]      = ptr;
      pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
   end

   assign idx         = pick[ID_W-1:0];
   assign hit         = pick[3];
   assign unused_pick = ^pick;

endmodule

// File: rtl/spi_tx_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the SPI TX CDC FIFO write port (write-clock domain).
// Define SPI_ARB_STATS_EN to add per-requester beat and FIFO-stall statistics counters.
module spi_tx_wr_arbiter import spi_arb_pkg::*; #(
   parameter  int unsigned NUM_REQ      = 3,
   parameter  int unsigned DATA_WIDTH   = 32,
   parameter  int unsigned BURST_MAX    = 4,
   parameter  int unsigned HOLD_TIMEOUT = 16,
   localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_winc,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   input  logic                          fifo_wfull,
   output logic [ID_W-1:0]               grant_id,
`ifdef SPI_ARB_STATS_EN
   input  logic                          stat_clr,
   output logic [NUM_REQ*STAT_WIDTH-1:0] stat_beats,
   output logic [STAT_WIDTH-1:0]         stat_stall,
`endif
   output logic                          busy
);

   localparam int unsigned BCW = $clog2(BURST_MAX) + 1;
   localparam int unsigned ICW = $clog2(HOLD_TIMEOUT) + 1;

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick_idx, grant_nxt;
   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ICW-1:0]   idle_cnt_q, idle_cnt_d;
   logic             pick_hit, locked, own_valid, own_last, idle_tick, release_now;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .idx (pick_idx),
      .hit (pick_hit)
   );

   assign locked    = (state_q == ARB_LOCK);
   assign own_valid = req_valid[grant_q];
   assign own_last  = req_last[grant_q];
   assign grant_nxt = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
   // A full FIFO stalls the owner; those cycles never count toward the hold timeout.
   assign idle_tick = locked && !own_valid && !fifo_wfull;

   assign release_now = (fifo_winc && (own_last || beat_cnt_q == BCW'(BURST_MAX - 1))) ||
                        (idle_tick && idle_cnt_q == ICW'(HOLD_TIMEOUT - 1));

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      idle_cnt_d = idle_cnt_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_hit) begin
               grant_d = pick_idx;
               state_d = ARB_LOCK;
            end
         end
         ARB_LOCK: begin
            if (fifo_winc) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               idle_cnt_d = '0;
            end else if (idle_tick) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (release_now) begin
               state_d    = ARB_IDLE;
               rr_ptr_d   = grant_nxt;
               beat_cnt_d = '0;
               idle_cnt_d = '0;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      busy      = locked;
      grant_id  = grant_q;
      req_ready = '0;
      if (locked && !fifo_wfull) begin
         req_ready[grant_q] = 1'b1;
      end
      fifo_winc  = locked && own_valid && !fifo_wfull;
      fifo_wdata = data_arr[grant_q];
   end

`ifdef SPI_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] beats_q [NUM_REQ];
   logic [STAT_WIDTH-1:0] stall_q;

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         for (int i = 0; i < NUM_REQ; i++) beats_q[i] <= '0;
         stall_q <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < NUM_REQ; i++) beats_q[i] <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (fifo_winc && grant_q == ID_W'(i) && beats_q[i] != '1) begin
               beats_q[i] <= beats_q[i] + 1'b1;
            end
         end
         if (locked && own_valid && fifo_wfull && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      assign stat_beats[i*STAT_WIDTH +: STAT_WIDTH] = beats_q[i];
   end
   assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_spi_tx_wr_arbiter.sv
// Self-checking bench for spi_tx_wr_arbiter: directed scenarios plus randomized model comparison.
module tb_spi_tx_wr_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned BM = 4;
   localparam int unsigned HT = 16;

   logic            wclk = 1'b0;
   logic            wrst;
   logic [NR-1:0]   req_valid, req_last, req_ready;
   logic [NR*DW-1:0] req_data;
   logic            fifo_winc, fifo_wfull, busy;
   logic [DW-1:0]   fifo_wdata;
   logic [1:0]      grant_id;
`ifdef SPI_ARB_STATS_EN
   logic            stat_clr;
   logic [NR*16-1:0] stat_beats;
   logic [15:0]     stat_stall;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 wclk = ~wclk;

   spi_tx_wr_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM), .HOLD_TIMEOUT(HT)
   ) dut (
      .wclk       (wclk),
      .wrst       (wrst),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_winc  (fifo_winc),
      .fifo_wdata (fifo_wdata),
      .fifo_wfull (fifo_wfull),
      .grant_id   (grant_id),
`ifdef SPI_ARB_STATS_EN
      .stat_clr   (stat_clr),
      .stat_beats (stat_beats),
      .stat_stall (stat_stall),
`endif
      .busy       (busy)
   );

   task automatic set_data(input int i, input logic [31:0] d);
      req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_wfull = 1'b0;
`ifdef SPI_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      @(negedge wclk);
      wrst = 1'b0;
   endtask

   task automatic test_reset();
      wrst = 1'b1; req_valid = '1; req_last = '0; req_data = '1; fifo_wfull = 1'b0;
`ifdef SPI_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      @(negedge wclk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", req_ready); else n_pass++;
      n_checks++; if (fifo_winc !== 1'b0) $display("FAIL reset_winc got %b want 0", fifo_winc); else n_pass++;
      n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_id); else n_pass++;
`ifdef SPI_ARB_STATS_EN
      n_checks++; if (stat_beats !== '0 || stat_stall !== '0)
         $display("FAIL reset_stats got %h/%h want 0", stat_beats, stat_stall); else n_pass++;
`endif
      @(negedge wclk); wrst = 1'b0; req_valid = '0;
      @(negedge wclk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_single_burst();
      do_reset();
      @(negedge wclk); req_valid = 3'b001; set_data(0, 32'hA); #1;
      n_checks++; if (busy !== 1'b0 || fifo_winc !== 1'b0)
         $display("FAIL single_arb_cycle got busy=%b winc=%b want 0/0", busy, fifo_winc); else n_pass++;
      @(negedge wclk); #1;
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0)
         $display("FAIL single_grant got busy=%b id=%0d want 1/0", busy, grant_id); else n_pass++;
      n_checks++; if (fifo_winc !== 1'b1 || fifo_wdata !== 32'hA)
         $display("FAIL single_beat_a got winc=%b data=%h want 1/a", fifo_winc, fifo_wdata); else n_pass++;
      @(negedge wclk); set_data(0, 32'hB); #1;
      n_checks++; if (fifo_winc !== 1'b1 || fifo_wdata !== 32'hB)
         $display("FAIL single_beat_b got winc=%b data=%h want 1/b", fifo_winc, fifo_wdata); else n_pass++;
      @(negedge wclk); set_data(0, 32'hC); req_last = 3'b001; #1;
      n_checks++; if (fifo_winc !== 1'b1 || fifo_wdata !== 32'hC || req_ready !== 3'b001)
         $display("FAIL single_beat_c got winc=%b data=%h rdy=%b want 1/c/001",
                  fifo_winc, fifo_wdata, req_ready); else n_pass++;
      // rr_ptr should now be 1: with req0 and req1 both valid, req1 wins
      @(negedge wclk); req_valid = 3'b011; req_last = 3'b010; set_data(1, 32'hD); #1;
      n_checks++; if (busy !== 1'b0 || fifo_winc !== 1'b0)
         $display("FAIL single_release got busy=%b winc=%b want 0/0", busy, fifo_winc); else n_pass++;
      @(negedge wclk); #1;
      n_checks++; if (grant_id !== 2'd1 || fifo_winc !== 1'b1 || fifo_wdata !== 32'hD)
         $display("FAIL single_rr_ptr got id=%0d winc=%b data=%h want 1/1/d",
                  grant_id, fifo_winc, fifo_wdata); else n_pass++;
      @(negedge wclk); req_valid = '0; req_last = '0; #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_end_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_round_robin();
      int cnt [NR];
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         int phase, own;
         logic exp_winc;
         logic [31:0] exp_data;
         @(negedge wclk);
         req_valid = '1; req_last = '0;
         for (int i = 0; i < NR; i++) set_data(i, {16'hA5A5, 8'(i), 8'(cnt[i])});
         #1;
         phase    = c % 5;
         own      = (c / 5) % NR;
         exp_winc = (phase != 0);
         exp_data = {16'hA5A5, 8'(own), 8'(cnt[own])};
         n_checks++; if (fifo_winc !== exp_winc)
            $display("FAIL rr_winc cyc%0d got %b want %b", c, fifo_winc, exp_winc); else n_pass++;
         if (exp_winc) begin
            n_checks++; if (grant_id !== 2'(own) || fifo_wdata !== exp_data)
               $display("FAIL rr_owner cyc%0d got id=%0d data=%h want %0d/%h",
                        c, grant_id, fifo_wdata, own, exp_data); else n_pass++;
            cnt[own]++;
         end
      end
   endtask

   task automatic test_wfull_stall();
      do_reset();
      @(negedge wclk); req_valid = 3'b010; set_data(1, 32'h1111_0001); #1;
      @(negedge wclk); #1;
      n_checks++; if (grant_id !== 2'd1 || fifo_winc !== 1'b1 || fifo_wdata !== 32'h1111_0001)
         $display("FAIL stall_first got id=%0d winc=%b data=%h", grant_id, fifo_winc, fifo_wdata);
      else n_pass++;
      @(negedge wclk); set_data(1, 32'h1111_0002); fifo_wfull = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge wclk);
         #1;
         n_checks++; if (req_ready !== 3'b000 || fifo_winc !== 1'b0 || busy !== 1'b1)
            $display("FAIL stall_hold cyc%0d got rdy=%b winc=%b busy=%b want 000/0/1",
                     k, req_ready, fifo_winc, busy); else n_pass++;
      end
      @(negedge wclk); fifo_wfull = 1'b0; #1;
      n_checks++; if (fifo_winc !== 1'b1 || fifo_wdata !== 32'h1111_0002 || req_ready !== 3'b010)
         $display("FAIL stall_resume got winc=%b data=%h rdy=%b want 1/11110002/010",
                  fifo_winc, fifo_wdata, req_ready); else n_pass++;
      @(negedge wclk); set_data(1, 32'h1111_0003); req_last = 3'b010; #1;
      n_checks++; if (fifo_winc !== 1'b1 || fifo_wdata !== 32'h1111_0003)
         $display("FAIL stall_last got winc=%b data=%h", fifo_winc, fifo_wdata); else n_pass++;
      @(negedge wclk); req_valid = '0; req_last = '0; #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL stall_release got busy=%b want 0", busy);
      else n_pass++;
   endtask

   task automatic test_hold_timeout();
      do_reset();
      @(negedge wclk); req_valid = 3'b100; set_data(2, 32'h2222_0001); #1;
      @(negedge wclk); #1;
      n_checks++; if (grant_id !== 2'd2 || fifo_winc !== 1'b1)
         $display("FAIL tmo_grant got id=%0d winc=%b want 2/1", grant_id, fifo_winc); else n_pass++;
      @(negedge wclk); req_valid = 3'b001; set_data(0, 32'h0000_00AA);
      for (int k = 0; k < HT; k++) begin
         if (k > 0) @(negedge wclk);
         #1;
         n_checks++; if (busy !== 1'b1 || grant_id !== 2'd2 || fifo_winc !== 1'b0)
            $display("FAIL tmo_hold cyc%0d got busy=%b id=%0d winc=%b want 1/2/0",
                     k, busy, grant_id, fifo_winc); else n_pass++;
      end
      @(negedge wclk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL tmo_bubble got busy=%b want 0", busy);
      else n_pass++;
      @(negedge wclk); #1;
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_winc !== 1'b1 ||
                      fifo_wdata !== 32'h0000_00AA)
         $display("FAIL tmo_next got busy=%b id=%0d winc=%b data=%h want 1/0/1/aa",
                  busy, grant_id, fifo_winc, fifo_wdata); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      @(negedge wclk); req_valid = 3'b010; req_last = 3'b010; set_data(1, 32'h3333_0001); #1;
      @(negedge wclk); #1;
      n_checks++; if (grant_id !== 2'd1 || fifo_winc !== 1'b1)
         $display("FAIL rstmid_pre got id=%0d winc=%b want 1/1", grant_id, fifo_winc); else n_pass++;
      @(negedge wclk); req_valid = 3'b110; req_last = '0; set_data(2, 32'h4444_0001); #1;
      @(negedge wclk); #1;
      n_checks++; if (grant_id !== 2'd2 || fifo_winc !== 1'b1)
         $display("FAIL rstmid_beat1 got id=%0d winc=%b want 2/1", grant_id, fifo_winc); else n_pass++;
      @(negedge wclk); set_data(2, 32'h4444_0002); #1;
      wrst = 1'b1; #1;
      n_checks++; if (busy !== 1'b0 || req_ready !== 3'b000 || fifo_winc !== 1'b0)
         $display("FAIL rstmid_async got busy=%b rdy=%b winc=%b want 0/000/0",
                  busy, req_ready, fifo_winc); else n_pass++;
      @(negedge wclk); #1;
      n_checks++; if (busy !== 1'b0 || fifo_winc !== 1'b0)
         $display("FAIL rstmid_held got busy=%b winc=%b want 0/0", busy, fifo_winc); else n_pass++;
      @(negedge wclk); wrst = 1'b0; #1;
      @(negedge wclk); #1;
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd1)
         $display("FAIL rstmid_restart got busy=%b id=%0d want 1/1", busy, grant_id); else n_pass++;
   endtask

   task automatic test_random();
      bit          m_busy = 1'b0;
      int          m_owner = 0, m_ptr = 0, m_beats = 0, m_idle = 0;
      logic [NR-1:0] v, l;
      logic [31:0] d [NR];
      logic        full;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [NR-1:0] exp_ready;
         logic          exp_winc;
         bit            quiet;
         @(negedge wclk);
         quiet = ((c / 100) % 3 == 2);
         for (int i = 0; i < NR; i++) begin
            v[i] = quiet ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
            l[i] = ($urandom_range(0, 5) == 0);
            d[i] = $urandom;
            set_data(i, d[i]);
         end
         full = ($urandom_range(0, 4) == 0);
         req_valid = v; req_last = l; fifo_wfull = full;
         exp_ready = (m_busy && !full) ? (3'b001 << m_owner) : 3'b000;
         exp_winc  = m_busy && v[m_owner] && !full;
         #1;
         n_checks++; if (busy !== m_busy)
            $display("FAIL rnd_busy cyc%0d got %b want %b", c, busy, m_busy); else n_pass++;
         n_checks++; if (req_ready !== exp_ready)
            $display("FAIL rnd_ready cyc%0d got %b want %b", c, req_ready, exp_ready); else n_pass++;
         n_checks++; if (fifo_winc !== exp_winc)
            $display("FAIL rnd_winc cyc%0d got %b want %b", c, fifo_winc, exp_winc); else n_pass++;
         if (m_busy) begin
            n_checks++; if (grant_id !== 2'(m_owner))
               $display("FAIL rnd_grant cyc%0d got %0d want %0d", c, grant_id, m_owner); else n_pass++;
         end
         if (exp_winc) begin
            n_checks++; if (fifo_wdata !== d[m_owner])
               $display("FAIL rnd_wdata cyc%0d got %h want %h", c, fifo_wdata, d[m_owner]);
            else n_pass++;
         end
         // Reference model: advance one clock
         if (!m_busy) begin
            for (int k = 0; k < NR; k++) begin
               int j;
               j = (m_ptr + k) % NR;
               if (!m_busy && v[j]) begin
                  m_busy  = 1'b1;
                  m_owner = j;
               end
            end
         end else if (exp_winc) begin
            m_beats++;
            m_idle = 0;
            if (l[m_owner] || m_beats == BM) begin
               m_busy = 1'b0; m_ptr = (m_owner + 1) % NR; m_beats = 0;
            end
         end else if (!v[m_owner] && !full) begin
            m_idle++;
            if (m_idle == HT) begin
               m_busy = 1'b0; m_ptr = (m_owner + 1) % NR; m_beats = 0; m_idle = 0;
            end
         end
      end
   endtask

`ifdef SPI_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge wclk);
         req_valid  = (c < 7) ? 3'b001 : (c < 11) ? 3'b010 : (c < 19) ? 3'b001 : 3'b000;
         req_last   = (c == 6) ? 3'b001 : (c == 10) ? 3'b010 : 3'b000;
         fifo_wfull = (c >= 11 && c <= 18);
         set_data(0, 32'(c)); set_data(1, 32'(c + 100));
      end
      @(negedge wclk); #1;
      n_checks++; if (stat_beats[15:0] !== 16'd5)
         $display("FAIL stat_beats0 got %0d want 5", stat_beats[15:0]); else n_pass++;
      n_checks++; if (stat_beats[31:16] !== 16'd3)
         $display("FAIL stat_beats1 got %0d want 3", stat_beats[31:16]); else n_pass++;
      n_checks++; if (stat_beats[47:32] !== 16'd0)
         $display("FAIL stat_beats2 got %0d want 0", stat_beats[47:32]); else n_pass++;
      n_checks++; if (stat_stall !== 16'd7)
         $display("FAIL stat_stall got %0d want 7", stat_stall); else n_pass++;
      @(negedge wclk); stat_clr = 1'b1;
      @(negedge wclk); stat_clr = 1'b0; #1;
      n_checks++; if (stat_beats !== '0 || stat_stall !== '0)
         $display("FAIL stat_clr got %h/%h want 0", stat_beats, stat_stall); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_wfull_stall();
      test_hold_timeout();
      test_reset_mid_burst();
      test_random();
`ifdef SPI_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
